// File: rtl/button_ctrl.sv
// Push-button front end: 2-flop synchroniser, debounce FSM, short/long press
// classification driving the blinker's mode select and enable.
module button_ctrl #(
  parameter int DEBOUNCE_CYCLES   = 1_000_000,
  parameter int LONG_PRESS_CYCLES = 50_000_000,
  parameter int NUM_MODES         = 4,
  parameter int BTN_ACTIVE_LOW    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       long_pulse,
  output logic [1:0] mode,
  output logic       blink_en
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES);
  localparam logic [DB_W-1:0]   DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [1:0]        MODE_LAST  = 2'(NUM_MODES - 1);
  localparam logic              IDLE_LEVEL = (BTN_ACTIVE_LOW != 0);

  typedef enum logic [2:0] {
    IDLE,
    DB_PRESS,
    PRESSED,
    LONG_HELD,
    DB_RELEASE
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        sync_q, sync_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              origin_long_q, origin_long_d;
  logic              btn_level_q, btn_level_d;
  logic              press_pulse_q, press_pulse_d;
  logic              long_pulse_q, long_pulse_d;
  logic [1:0]        mode_q, mode_d;
  logic              blink_en_q, blink_en_d;
  logic              btn_sync;

  assign sync_d   = {sync_q[0], btn_in};
  assign btn_sync = sync_q[1] ^ IDLE_LEVEL;

  always_comb begin
    state_d       = state_q;
    db_cnt_d      = db_cnt_q;
    hold_cnt_d    = hold_cnt_q;
    origin_long_d = origin_long_q;
    btn_level_d   = btn_level_q;
    press_pulse_d = 1'b0;
    long_pulse_d  = 1'b0;
    mode_d        = mode_q;
    blink_en_d    = blink_en_q;
    case (state_q)
      IDLE: begin
        btn_level_d = 1'b0;
        if (btn_sync) begin
          state_d  = DB_PRESS;
          db_cnt_d = '0;
        end
      end
      DB_PRESS: begin
        if (!btn_sync) begin
          state_d = IDLE;
        end else if (db_cnt_q == DB_LAST) begin
          state_d     = PRESSED;
          btn_level_d = 1'b1;
          hold_cnt_d  = '0;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        // Reaching the long-press threshold wins over a coincident release sample.
        if (hold_cnt_q == HOLD_LAST) begin
          state_d      = LONG_HELD;
          long_pulse_d = 1'b1;
          blink_en_d   = !blink_en_q;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
          if (!btn_sync) begin
            state_d       = DB_RELEASE;
            origin_long_d = 1'b0;
            db_cnt_d      = '0;
          end
        end
      end
      LONG_HELD: begin
        if (!btn_sync) begin
          state_d       = DB_RELEASE;
          origin_long_d = 1'b1;
          db_cnt_d      = '0;
        end
      end
      DB_RELEASE: begin
        if (btn_sync) begin
          state_d = origin_long_q ? LONG_HELD : PRESSED;
        end else if (db_cnt_q == DB_LAST) begin
          state_d     = IDLE;
          btn_level_d = 1'b0;
          if (!origin_long_q) begin
            press_pulse_d = 1'b1;
            mode_d        = (mode_q == MODE_LAST) ? 2'd0 : mode_q + 2'd1;
          end
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q        <= {2{IDLE_LEVEL}};
      state_q       <= IDLE;
      db_cnt_q      <= '0;
      hold_cnt_q    <= '0;
      origin_long_q <= 1'b0;
      btn_level_q   <= 1'b0;
      press_pulse_q <= 1'b0;
      long_pulse_q  <= 1'b0;
      mode_q        <= 2'd0;
      blink_en_q    <= 1'b1;
    end else begin
      sync_q        <= sync_d;
      state_q       <= state_d;
      db_cnt_q      <= db_cnt_d;
      hold_cnt_q    <= hold_cnt_d;
      origin_long_q <= origin_long_d;
      btn_level_q   <= btn_level_d;
      press_pulse_q <= press_pulse_d;
      long_pulse_q  <= long_pulse_d;
      mode_q        <= mode_d;
      blink_en_q    <= blink_en_d;
    end
  end

  assign btn_level   = btn_level_q;
  assign press_pulse = press_pulse_q;
  assign long_pulse  = long_pulse_q;
  assign mode        = mode_q;
  assign blink_en    = blink_en_q;

endmodule

// File: tb/tb_button_ctrl.sv
// Self-checking bench for button_ctrl: directed scenarios plus random bouncing
// input, compared every cycle against a run-length based reference model.
module tb_button_ctrl;

  localparam int D = 4;
  localparam int L = 20;
  localparam int N = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_in = 1'b1;
  logic       btn_level, press_pulse, long_pulse, blink_en;
  logic [1:0] mode;

  int checks = 0;
  int errors = 0;

  button_ctrl #(
    .DEBOUNCE_CYCLES(D), .LONG_PRESS_CYCLES(L), .NUM_MODES(N), .BTN_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in), .btn_level(btn_level),
    .press_pulse(press_pulse), .long_pulse(long_pulse), .mode(mode), .blink_en(blink_en)
  );

  always #5 clk = ~clk;

  // Reference model: debounced level flips once D+1 consecutive samples
  // disagree with it; hold time counts cycles held with no pending release.
  bit dly[$];
  bit m_level, m_long, m_blink, m_press_p, m_long_p;
  int m_run, m_hold, m_mode;

  task automatic model_edge();
    bit s;
    bit holding;
    if (rst) begin
      dly = '{1'b0, 1'b0};
      m_level = 0; m_run = 0; m_hold = 0; m_long = 0; m_mode = 0;
      m_blink = 1; m_press_p = 0; m_long_p = 0;
      return;
    end
    s = dly.pop_front();
    dly.push_back(!btn_in);
    m_press_p = 0;
    m_long_p  = 0;
    holding = m_level && (m_run == 0) && !m_long;
    if (holding && m_hold == L - 1) begin
      m_long = 1; m_long_p = 1; m_blink = !m_blink;
    end else begin
      if (holding) m_hold++;
      if (s != m_level) begin
        m_run++;
        if (m_run == D + 1) begin
          m_run = 0;
          if (!m_level) begin
            m_level = 1; m_hold = 0;
          end else begin
            m_level = 0;
            if (!m_long) begin m_press_p = 1; m_mode = (m_mode + 1) % N; end
            m_long = 0;
          end
        end
      end else begin
        m_run = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic logic [5:0] obs_vec();
    return {btn_level, press_pulse, long_pulse, mode, blink_en};
  endfunction

  function automatic logic [5:0] exp_vec();
    return {m_level, m_press_p, m_long_p, 2'(m_mode), m_blink};
  endfunction

  task automatic test_reset();
    int pulses = 0;
    rst = 1; btn_in = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs_vec() !== 6'b0_0_0_00_1) begin
        errors++; $display("FAIL reset_vals cyc=%0d got %b want %b", i, obs_vec(), 6'b000001);
      end
    end
    rst = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL reset_idle cyc=%0d got %b want %b", i, obs_vec(), exp_vec());
      end
      if (press_pulse || long_pulse || btn_level) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++; $display("FAIL reset_quiet got %0d active cycles want 0", pulses);
    end
    $display("reset: idle 50 cycles, active=%0d", pulses);
  endtask

  task automatic test_bounce();
    int active = 0;
    for (int i = 0; i < 50; i++) begin
      btn_in = (i < 40 && (i % 5) < 3) ? 1'b0 : 1'b1;
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL bounce cyc=%0d got %b want %b", i, obs_vec(), exp_vec());
      end
      if (btn_level || press_pulse || long_pulse) active++;
    end
    checks++;
    if (active !== 0) begin
      errors++; $display("FAIL bounce_reject got %0d active cycles want 0", active);
    end
    $display("bounce: 40 cycles toggling, active=%0d", active);
  endtask

  task automatic test_short_press();
    int rise_at, fall_at, pulse_at, pulses;
    for (int p = 0; p < 3; p++) begin
      rise_at = -1; fall_at = -1; pulse_at = -1; pulses = 0;
      for (int i = 0; i < 30; i++) begin
        btn_in = (i < 10) ? 1'b0 : 1'b1;
        tick();
        checks++;
        if (obs_vec() !== exp_vec()) begin
          errors++; $display("FAIL short p=%0d cyc=%0d got %b want %b", p, i, obs_vec(), exp_vec());
        end
        if (btn_level && rise_at < 0) rise_at = i;
        if (!btn_level && rise_at >= 0 && fall_at < 0) fall_at = i;
        if (press_pulse) begin pulses++; pulse_at = i; end
      end
      checks += 4;
      if (rise_at !== 2 + D) begin
        errors++; $display("FAIL short_rise got %0d want %0d", rise_at, 2 + D);
      end
      if (fall_at !== 10 + 2 + D) begin
        errors++; $display("FAIL short_fall got %0d want %0d", fall_at, 12 + D);
      end
      if (pulses !== 1 || pulse_at !== fall_at) begin
        errors++; $display("FAIL short_pulse got %0d at %0d want 1 at %0d", pulses, pulse_at, fall_at);
      end
      if (mode !== 2'((p + 1) % N)) begin
        errors++; $display("FAIL short_mode got %0d want %0d", mode, (p + 1) % N);
      end
      $display("short press %0d: rise=%0d fall=%0d pulses=%0d mode=%0d", p, rise_at, fall_at, pulses, mode);
    end
  endtask

  task automatic test_long_press();
    int rise_at, long_at, longs, presses;
    for (int p = 0; p < 2; p++) begin
      rise_at = -1; long_at = -1; longs = 0; presses = 0;
      for (int i = 0; i < 60; i++) begin
        btn_in = (i < 40) ? 1'b0 : 1'b1;
        tick();
        checks++;
        if (obs_vec() !== exp_vec()) begin
          errors++; $display("FAIL long p=%0d cyc=%0d got %b want %b", p, i, obs_vec(), exp_vec());
        end
        if (btn_level && rise_at < 0) rise_at = i;
        if (long_pulse) begin longs++; long_at = i; end
        if (press_pulse) presses++;
      end
      checks += 3;
      if (longs !== 1 || long_at !== 2 + D + L) begin
        errors++; $display("FAIL long_pulse got %0d at %0d want 1 at %0d", longs, long_at, 2 + D + L);
      end
      if (presses !== 0 || mode !== 2'd0) begin
        errors++; $display("FAIL long_no_short got presses=%0d mode=%0d want 0 0", presses, mode);
      end
      if (blink_en !== (p == 1)) begin
        errors++; $display("FAIL long_blink got %0d want %0d", blink_en, p == 1);
      end
      $display("long press %0d: rise=%0d long_at=%0d blink_en=%0d", p, rise_at, long_at, blink_en);
    end
  endtask

  task automatic test_reset_mid_hold();
    int rise_at = -1, long_at = -1, presses = 0;
    btn_in = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL midrst_pre cyc=%0d got %b want %b", i, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (blink_en !== 1'b0) begin
      errors++; $display("FAIL midrst_blink_before got %0d want 0", blink_en);
    end
    rst = 1;
    tick();
    rst = 0;
    checks++;
    if (obs_vec() !== 6'b0_0_0_00_1) begin
      errors++; $display("FAIL midrst_reset got %b want %b", obs_vec(), 6'b000001);
    end
    for (int i = 0; i < 60; i++) begin
      btn_in = (i < 40) ? 1'b0 : 1'b1;
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL midrst cyc=%0d got %b want %b", i, obs_vec(), exp_vec());
      end
      if (btn_level && rise_at < 0) rise_at = i;
      if (long_pulse && long_at < 0) long_at = i;
      if (press_pulse) presses++;
    end
    checks += 2;
    if (rise_at !== 2 + D || long_at !== 2 + D + L) begin
      errors++; $display("FAIL midrst_timing got rise=%0d long=%0d want %0d %0d", rise_at, long_at, 2 + D, 2 + D + L);
    end
    if (presses !== 0) begin
      errors++; $display("FAIL midrst_no_press got %0d want 0", presses);
    end
    $display("reset mid-hold: rise=%0d long_at=%0d", rise_at, long_at);
  endtask

  task automatic test_release_glitch();
    int hold_len, rises, falls, presses, longs, long_at, total;
    for (int sc = 0; sc < 2; sc++) begin
      hold_len = (sc == 0) ? 10 : 40;
      total = 12 + hold_len + 20;
      rises = 0; falls = 0; presses = 0; longs = 0; long_at = -1;
      for (int i = 0; i < total; i++) begin
        btn_in = (i < 10 || (i >= 12 && i < 12 + hold_len)) ? 1'b0 : 1'b1;
        tick();
        checks++;
        if (obs_vec() !== exp_vec()) begin
          errors++; $display("FAIL glitch sc=%0d cyc=%0d got %b want %b", sc, i, obs_vec(), exp_vec());
        end
        if (btn_level && rises == falls) rises++;
        if (!btn_level && rises > falls) falls++;
        if (press_pulse) presses++;
        if (long_pulse) begin longs++; long_at = i; end
      end
      checks += 2;
      if (rises !== 1 || falls !== 1) begin
        errors++; $display("FAIL glitch_level got rises=%0d falls=%0d want 1 1", rises, falls);
      end
      if (sc == 0 && (presses !== 1 || longs !== 0)) begin
        errors++; $display("FAIL glitch_short got press=%0d long=%0d want 1 0", presses, longs);
      end
      if (sc == 1 && (presses !== 0 || longs !== 1 || long_at !== 2 + D + L + 2)) begin
        errors++; $display("FAIL glitch_long got press=%0d long=%0d at %0d want 0 1 at %0d",
                           presses, longs, long_at, 2 + D + L + 2);
      end
      $display("release glitch %0d: press=%0d long=%0d long_at=%0d", sc, presses, longs, long_at);
    end
  endtask

  task automatic test_random();
    int run_left = 0;
    int bad = 0;
    for (int i = 0; i < 1500; i++) begin
      if (run_left == 0) begin
        btn_in = 1'($urandom_range(0, 1));
        run_left = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 40) : $urandom_range(1, 8);
      end
      run_left--;
      rst = ($urandom_range(0, 199) == 0);
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; bad++;
        $display("FAIL random cyc=%0d got %b want %b", i, obs_vec(), exp_vec());
      end
    end
    rst = 0;
    $display("random: 1500 cycles, mismatches=%0d", bad);
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_short_press();
    test_long_press();
    test_reset_mid_hold();
    test_release_glitch();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
